rle_encoder: RTL and testbench
==============================

RLE_ENCODER -- requirements
Module: rle_encoder

Interface
REQ-001 The block SHALL have parameter MAX_RUN, default 1023, meaning the longest run in one word; legal range 1..1023.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port pixel_valid  input  1  pixel_colour/row_end/frame_end are valid.
REQ-005 The block SHALL have port pixel_colour  input  6  pixel colour, {R1,R0,G1,G0,B1,B0}.
REQ-006 The block SHALL have port row_end  input  1  this pixel is the last of its row.
REQ-007 The block SHALL have port frame_end  input  1  this pixel is the last of its frame; implies row_end.
REQ-008 The block SHALL have port pixel_ready  output  1  pixel accepted when pixel_valid && pixel_ready.
REQ-009 The block SHALL have port word_valid  output  1  word_data holds an RLE word.
REQ-010 The block SHALL have port word_data  output  16  RLE word {run_len[9:0], colour[5:0]}.
REQ-011 The block SHALL have port word_ready  input  1  word consumed when word_valid && word_ready.

Function
REQ-012 The block SHALL emit run words with run_len = 1..MAX_RUN consecutive same-colour pixels; run_len 0 is reserved for the end-of-frame marker 16'h0000.
REQ-013 The block SHALL implement states EMPTY (no open run), RUN (open run), FLUSH (open run awaiting emission, input stalled), MARK (marker awaiting emission, input stalled).
REQ-014 The block SHALL drive pixel_ready = (state is EMPTY or RUN) && (!word_valid || word_ready).
REQ-015 EMPTY, pixel accepted: the block SHALL open run {1, colour}; go RUN, or go FLUSH if row_end.
REQ-016 RUN, pixel accepted, same colour, len < MAX_RUN, no row_end: the block SHALL increment len, emit nothing.
REQ-017 RUN, same colour, len < MAX_RUN, row_end: the block SHALL load {len+1, colour} into the output register at that edge and go EMPTY, or MARK if frame_end.
REQ-018 RUN, colour differs or len == MAX_RUN: the block SHALL load the open run into the output register at that edge, open run {1, new colour}, stay RUN, or go FLUSH if row_end.
REQ-019 FLUSH: when !word_valid || word_ready the block SHALL load the open run and go EMPTY, or MARK if the latched frame_end is set.
REQ-020 MARK: when !word_valid || word_ready the block SHALL load 16'h0000 and go EMPTY.
REQ-021 Runs SHALL never span row_end; frame_end without row_end SHALL be treated as row_end && frame_end.
REQ-022 word_valid SHALL rise the cycle after the loading edge; word_data SHALL remain stable while word_valid && !word_ready.
REQ-023 Load and consume in the same cycle SHALL keep word_valid high with the new word (no bubble).
REQ-024 Pixels with pixel_valid low SHALL leave state unchanged; no timeout flush.

Reset
REQ-025 While rst is high at a clk edge the block SHALL enter EMPTY, clear open run and latched frame_end, drive word_valid=0, word_data=16'h0000; pixel_ready=0 during reset.
REQ-026 Reset mid-run or mid-FLUSH/MARK SHALL discard all pending data without emitting any word.

Configuration
REQ-027 With macro RLE_ENCODER_FRAME_MARKER_EN defined the block SHALL implement MARK and emit 16'h0000 after the last run of each frame.
REQ-028 Without RLE_ENCODER_FRAME_MARKER_EN the block SHALL omit MARK; frame_end SHALL behave exactly as row_end and no marker word is emitted.

Verification
REQ-029 Reset then 4 pixels 0x15 (4th row_end), word_ready=1 -> exactly one word 16'h0115 one cycle after 4th accept.
REQ-030 Pixels 0x3F,0x3F,0x00 (last row_end+frame_end), macro defined, word_ready=1 -> 16'h00BF, 16'h0040, 16'h0000 in order; pixel_ready low during FLUSH/MARK.
REQ-031 MAX_RUN=1023, 1030 pixels 0x2A (last row_end) -> 16'hFFEA then 16'h01EA.
REQ-032 word_ready held 0 for 10 cycles during a colour change -> word_data stable, pixel_ready 0, no pixel lost; release -> stream resumes with no bubble.
REQ-033 rst pulsed mid-run of 5 pixels, then 2 pixels 0x01 (row_end) -> only 16'h0081 emitted.
REQ-034 Macro undefined, pixel 0x07 with frame_end only -> single word 16'h0047, no 16'h0000.

Source files
------------

// File: rtl/rle_encoder.sv
// rle_encoder: packs runs of same-colour pixels into 16-bit {run_len[9:0], colour[5:0]} words.
// Define RLE_ENCODER_FRAME_MARKER_EN to append a 16'h0000 marker word after the last run of each frame.
module rle_encoder #(
  parameter int MAX_RUN = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pixel_valid,
  input  logic [5:0]  pixel_colour,
  input  logic        row_end,
  input  logic        frame_end,
  output logic        pixel_ready,
  output logic        word_valid,
  output logic [15:0] word_data,
  input  logic        word_ready
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_MARK  = 2'd3;
  localparam logic [9:0] MAX_LEN = 10'(MAX_RUN);

  logic [1:0]  r_state;
  logic [9:0]  r_len;
  logic [5:0]  r_colour;
  logic        r_frame;
  logic        r_word_valid;
  logic [15:0] r_word_data;

  logic w_out_free;
  logic w_row_end;
  logic w_frame_end;
  logic w_extend;
  logic w_pixel_ready;
  logic w_accept;

  // Handshake qualifiers and run-continuation decision for the incoming pixel
  always_comb begin
    w_out_free = !r_word_valid || word_ready;
    // frame_end always closes the row; it only arms the marker when the feature is built in
    w_row_end  = row_end || frame_end;
`ifdef RLE_ENCODER_FRAME_MARKER_EN
    w_frame_end = frame_end;
`else
    w_frame_end = 1'b0;
`endif
    w_extend = (pixel_colour == r_colour) && (r_len < MAX_LEN);
    if (rst) begin
      w_pixel_ready = 1'b0;
    end else begin
      w_pixel_ready = ((r_state == S_EMPTY) || (r_state == S_RUN)) && w_out_free;
    end
    w_accept = pixel_valid && w_pixel_ready;
  end

  // Run tracking state machine and output word register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_EMPTY;
      r_len        <= 10'd0;
      r_colour     <= 6'd0;
      r_frame      <= 1'b0;
      r_word_valid <= 1'b0;
      r_word_data  <= 16'h0000;
    end else begin
      // A consumed word drops valid unless a new word is loaded on the same edge below
      if (r_word_valid && word_ready) begin
        r_word_valid <= 1'b0;
      end
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_len    <= 10'd1;
            r_colour <= pixel_colour;
            r_frame  <= w_frame_end;
            r_state  <= w_row_end ? S_FLUSH : S_RUN;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            if (w_extend) begin
              if (w_row_end) begin
                r_word_valid <= 1'b1;
                r_word_data  <= {r_len + 10'd1, r_colour};
                r_len        <= 10'd0;
                r_frame      <= 1'b0;
                r_state      <= w_frame_end ? S_MARK : S_EMPTY;
              end else begin
                r_len <= r_len + 10'd1;
              end
            end else begin
              r_word_valid <= 1'b1;
              r_word_data  <= {r_len, r_colour};
              r_len        <= 10'd1;
              r_colour     <= pixel_colour;
              r_frame      <= w_frame_end;
              r_state      <= w_row_end ? S_FLUSH : S_RUN;
            end
          end
        end
        S_FLUSH: begin
          if (w_out_free) begin
            r_word_valid <= 1'b1;
            r_word_data  <= {r_len, r_colour};
            r_len        <= 10'd0;
            r_frame      <= 1'b0;
            r_state      <= r_frame ? S_MARK : S_EMPTY;
          end
        end
`ifdef RLE_ENCODER_FRAME_MARKER_EN
        S_MARK: begin
          if (w_out_free) begin
            r_word_valid <= 1'b1;
            r_word_data  <= 16'h0000;
            r_state      <= S_EMPTY;
          end
        end
`endif
        default: begin
          r_state <= S_EMPTY;
        end
      endcase
    end
  end

  assign pixel_ready = w_pixel_ready;
  assign word_valid  = r_word_valid;
  assign word_data   = r_word_data;

endmodule

// File: tb/tb_rle_encoder.sv
// Directed self-checking bench for rle_encoder; expectations follow RLE_ENCODER_FRAME_MARKER_EN if defined.
module tb_rle_encoder;

  logic        clk;
  logic        rst;
  logic        pixel_valid;
  logic [5:0]  pixel_colour;
  logic        row_end;
  logic        frame_end;
  logic        pixel_ready;
  logic        word_valid;
  logic [15:0] word_data;
  logic        word_ready;

  int checks;
  int fails;
  logic [15:0] words [$];

  rle_encoder #(.MAX_RUN(1023)) dut (
    .clk          (clk),
    .rst          (rst),
    .pixel_valid  (pixel_valid),
    .pixel_colour (pixel_colour),
    .row_end      (row_end),
    .frame_end    (frame_end),
    .pixel_ready  (pixel_ready),
    .word_valid   (word_valid),
    .word_data    (word_data),
    .word_ready   (word_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every word transferred on the following rising edge
  always @(negedge clk) begin
    if (!rst && word_valid && word_ready) words.push_back(word_data);
  end

  task automatic send_pixel(input logic [5:0] c, input logic re, input logic fe);
    int n;
    n = 0;
    pixel_valid  = 1'b1;
    pixel_colour = c;
    row_end      = re;
    frame_end    = fe;
    @(negedge clk);
    while (!pixel_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (pixel_ready !== 1'b1) begin
      fails++;
      $display("FAIL accept_timeout: pixel_ready=%b required 1 for colour %h", pixel_ready, c);
    end
    @(posedge clk);
    #1;
    pixel_valid = 1'b0;
    row_end     = 1'b0;
    frame_end   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst         = 1'b1;
    pixel_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (word_valid !== 1'b0 || word_data !== 16'h0000 || pixel_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: valid=%b data=%h ready=%b required 0 0000 0", word_valid, word_data, pixel_ready);
    end
    @(posedge clk);
    #1;
    rst         = 1'b0;
    pixel_valid = 1'b0;
  endtask

  task automatic test_basic_run;
    int base;
    word_ready = 1'b1;
    base = words.size();
    for (int i = 0; i < 4; i++) send_pixel(6'h15, (i == 3) ? 1'b1 : 1'b0, 1'b0);
    checks++;
    if (word_valid !== 1'b1 || word_data !== 16'h0115) begin
      fails++;
      $display("FAIL basic_latency: valid=%b data=%h required 1 0115", word_valid, word_data);
    end
    idle(4);
    checks++;
    if (words.size() != base + 1) begin
      fails++;
      $display("FAIL basic_count: got %0d words required 1", words.size() - base);
    end else begin
      checks++;
      if (words[base] !== 16'h0115) begin
        fails++;
        $display("FAIL basic_word: got %h required 0115", words[base]);
      end
    end
  endtask

  task automatic test_frame_marker;
    int base;
    logic [15:0] exp_w [3];
    int exp_n;
    exp_w[0] = 16'h00BF;
    exp_w[1] = 16'h0040;
    exp_w[2] = 16'h0000;
`ifdef RLE_ENCODER_FRAME_MARKER_EN
    exp_n = 3;
`else
    exp_n = 2;
`endif
    base = words.size();
    send_pixel(6'h3F, 1'b0, 1'b0);
    send_pixel(6'h3F, 1'b0, 1'b0);
    send_pixel(6'h00, 1'b1, 1'b1);
    checks++;
    if (pixel_ready !== 1'b0) begin
      fails++;
      $display("FAIL flush_stall: pixel_ready=%b required 0", pixel_ready);
    end
    idle(1);
    checks++;
    if (pixel_ready !== ((exp_n == 3) ? 1'b0 : 1'b1)) begin
      fails++;
      $display("FAIL mark_stall: pixel_ready=%b required %b", pixel_ready, (exp_n == 3) ? 1'b0 : 1'b1);
    end
    idle(4);
    checks++;
    if (words.size() != base + exp_n) begin
      fails++;
      $display("FAIL frame_count: got %0d words required %0d", words.size() - base, exp_n);
    end else begin
      for (int i = 0; i < exp_n; i++) begin
        checks++;
        if (words[base + i] !== exp_w[i]) begin
          fails++;
          $display("FAIL frame_word%0d: got %h required %h", i, words[base + i], exp_w[i]);
        end
      end
    end
  endtask

  task automatic test_max_run;
    int base;
    base = words.size();
    for (int i = 0; i < 1030; i++) send_pixel(6'h2A, (i == 1029) ? 1'b1 : 1'b0, 1'b0);
    idle(4);
    checks++;
    if (words.size() != base + 2) begin
      fails++;
      $display("FAIL maxrun_count: got %0d words required 2", words.size() - base);
    end else begin
      checks++;
      if (words[base] !== 16'hFFEA || words[base + 1] !== 16'h01EA) begin
        fails++;
        $display("FAIL maxrun_words: got %h %h required FFEA 01EA", words[base], words[base + 1]);
      end
    end
  endtask

  task automatic test_back_pressure;
    int base;
    int bad;
    base = words.size();
    bad  = 0;
    word_ready = 1'b0;
    send_pixel(6'h05, 1'b0, 1'b0);
    send_pixel(6'h05, 1'b0, 1'b0);
    send_pixel(6'h09, 1'b0, 1'b0);
    pixel_valid  = 1'b1;
    pixel_colour = 6'h0C;
    row_end      = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (word_valid !== 1'b1 || word_data !== 16'h0085 || pixel_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL stall_hold: %0d bad cycles, last valid=%b data=%h ready=%b required 1 0085 0",
               bad, word_valid, word_data, pixel_ready);
    end
    @(posedge clk);
    #1;
    word_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (pixel_ready !== 1'b1) begin
      fails++;
      $display("FAIL release_ready: pixel_ready=%b required 1", pixel_ready);
    end
    @(posedge clk);
    #1;
    pixel_valid = 1'b0;
    row_end     = 1'b0;
    checks++;
    if (word_valid !== 1'b1 || word_data !== 16'h0049) begin
      fails++;
      $display("FAIL no_bubble: valid=%b data=%h required 1 0049", word_valid, word_data);
    end
    idle(4);
    checks++;
    if (words.size() != base + 3) begin
      fails++;
      $display("FAIL bp_count: got %0d words required 3", words.size() - base);
    end else begin
      checks++;
      if (words[base] !== 16'h0085 || words[base + 1] !== 16'h0049 || words[base + 2] !== 16'h004C) begin
        fails++;
        $display("FAIL bp_words: got %h %h %h required 0085 0049 004C",
                 words[base], words[base + 1], words[base + 2]);
      end
    end
  endtask

  task automatic test_reset_mid_run;
    int base;
    base = words.size();
    for (int i = 0; i < 5; i++) send_pixel(6'h11, 1'b0, 1'b0);
    test_reset();
    idle(3);
    checks++;
    if (words.size() != base) begin
      fails++;
      $display("FAIL reset_discard: got %0d words required 0", words.size() - base);
    end
    send_pixel(6'h01, 1'b0, 1'b0);
    send_pixel(6'h01, 1'b1, 1'b0);
    idle(4);
    checks++;
    if (words.size() != base + 1) begin
      fails++;
      $display("FAIL post_reset_count: got %0d words required 1", words.size() - base);
    end else begin
      checks++;
      if (words[base] !== 16'h0081) begin
        fails++;
        $display("FAIL post_reset_word: got %h required 0081", words[base]);
      end
    end
  endtask

  task automatic test_frame_end_only;
    int base;
    int exp_n;
`ifdef RLE_ENCODER_FRAME_MARKER_EN
    exp_n = 2;
`else
    exp_n = 1;
`endif
    base = words.size();
    send_pixel(6'h07, 1'b0, 1'b1);
    idle(5);
    checks++;
    if (words.size() != base + exp_n) begin
      fails++;
      $display("FAIL fe_only_count: got %0d words required %0d", words.size() - base, exp_n);
    end else begin
      checks++;
      if (words[base] !== 16'h0047) begin
        fails++;
        $display("FAIL fe_only_word: got %h required 0047", words[base]);
      end
    end
  endtask

  initial begin
    checks       = 0;
    fails        = 0;
    rst          = 1'b1;
    pixel_valid  = 1'b0;
    pixel_colour = 6'h00;
    row_end      = 1'b0;
    frame_end    = 1'b0;
    word_ready   = 1'b1;
    test_reset();
    test_basic_run();
    test_frame_marker();
    test_max_run();
    test_back_pressure();
    test_reset_mid_run();
    test_frame_end_only();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
